// File: rtl/mul_cmplx_seq_if.sv
// Handshake and shared-multiplier bus for the complex-multiply sequencer.
// Master is the datapath/multiplier side; slave is the sequencer.
interface mul_cmplx_seq_if #(
    parameter int WIDTH  = 8,
    parameter int PWIDTH = 2*WIDTH-1
);
    logic                     in_valid;
    logic                     in_ready;
    logic signed [WIDTH-1:0]  ar_in;
    logic signed [WIDTH-1:0]  ai_in;
    logic signed [WIDTH-1:0]  br_in;
    logic signed [WIDTH-1:0]  bi_in;
    logic                     out_valid;
    logic                     out_ready;
    logic signed [PWIDTH:0]   re_out;
    logic signed [PWIDTH:0]   im_out;
    logic signed [WIDTH-1:0]  mul_a;
    logic signed [WIDTH-1:0]  mul_b;
    logic                     mul_start;
    logic                     mul_ready;
    logic signed [PWIDTH-1:0] mul_product;

    modport master (
        output in_valid, ar_in, ai_in, br_in, bi_in, out_ready, mul_ready, mul_product,
        input  in_ready, out_valid, re_out, im_out, mul_a, mul_b, mul_start
    );

    modport slave (
        input  in_valid, ar_in, ai_in, br_in, bi_in, out_ready, mul_ready, mul_product,
        output in_ready, out_valid, re_out, im_out, mul_a, mul_b, mul_start
    );
endinterface

// File: rtl/mul_cmplx_seq.sv
// Complex product sequencer: four real multiplies through one shared multi-cycle multiplier.
// Optional watchdog on the multiplier answer: define MUL_TIMEOUT_EN.
module mul_cmplx_seq #(
    parameter int WIDTH       = 8,
    parameter int PWIDTH      = 2*WIDTH-1,
    parameter int TIMEOUT_CYC = 64
) (
    input  logic           clkin,
    input  logic           rstn,
    mul_cmplx_seq_if.slave bus,
    output logic           busy,
    output logic           err
);
    typedef enum logic [1:0] {IDLE, ISSUE, WAIT, DONE} state_t;

    state_t                  state, state_nx;
    logic signed [WIDTH-1:0] ar_q, ai_q, br_q, bi_q;
    logic [1:0]              idx;
    logic signed [PWIDTH:0]  re_acc, im_acc, re_q, im_q, prod_ext;
    logic                    out_valid_q;
    logic                    timeout;

    if (TIMEOUT_CYC < 2) begin : g_bad_timeout
        $error("TIMEOUT_CYC must be at least 2");
    end

    assign prod_ext   = {bus.mul_product[PWIDTH-1], bus.mul_product};
    assign bus.out_valid = out_valid_q;
    assign bus.re_out    = re_q;
    assign bus.im_out    = im_q;

`ifdef MUL_TIMEOUT_EN
    localparam int WD_W = (TIMEOUT_CYC > 2) ? $clog2(TIMEOUT_CYC) : 1;
    logic [WD_W-1:0] wd_cnt;

    always_ff @(posedge clkin or negedge rstn) begin
        if (!rstn)                           wd_cnt <= '0;
        else if (state == ISSUE)             wd_cnt <= '0;
        else if (state == WAIT && !timeout)  wd_cnt <= wd_cnt + WD_W'(1);
    end

    assign timeout = (state == WAIT) && !bus.mul_ready && (wd_cnt == WD_W'(TIMEOUT_CYC-1));

    always_ff @(posedge clkin or negedge rstn) begin
        if (!rstn)        err <= 1'b0;
        else if (timeout) err <= 1'b1;
    end
`else
    assign timeout = 1'b0;
    assign err     = 1'b0;
`endif

    always_ff @(posedge clkin or negedge rstn) begin
        if (!rstn) state <= IDLE;
        else       state <= state_nx;
    end

    always_comb begin
        state_nx = state;
        case (state)
            IDLE:  if (bus.in_valid) state_nx = ISSUE;
            ISSUE: state_nx = WAIT;
            WAIT: begin
                if (bus.mul_ready) state_nx = (idx == 2'd3) ? DONE : ISSUE;
                else if (timeout)  state_nx = DONE;
            end
            DONE:  if (out_valid_q && bus.out_ready) state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    // Operand pair order: ar*br, ai*bi, ar*bi, ai*br.
    always_comb begin
        bus.in_ready  = (state == IDLE);
        busy          = (state != IDLE);
        bus.mul_start = (state == ISSUE);
        bus.mul_a     = '0;
        bus.mul_b     = '0;
        if (state == ISSUE || state == WAIT) begin
            case (idx)
                2'd0:    begin bus.mul_a = ar_q; bus.mul_b = br_q; end
                2'd1:    begin bus.mul_a = ai_q; bus.mul_b = bi_q; end
                2'd2:    begin bus.mul_a = ar_q; bus.mul_b = bi_q; end
                default: begin bus.mul_a = ai_q; bus.mul_b = br_q; end
            endcase
        end
    end

    always_ff @(posedge clkin or negedge rstn) begin
        if (!rstn) begin
            ar_q        <= '0;
            ai_q        <= '0;
            br_q        <= '0;
            bi_q        <= '0;
            re_acc      <= '0;
            im_acc      <= '0;
            idx         <= '0;
            out_valid_q <= 1'b0;
            re_q        <= '0;
            im_q        <= '0;
        end else begin
            case (state)
                IDLE: if (bus.in_valid) begin
                    ar_q   <= bus.ar_in;
                    ai_q   <= bus.ai_in;
                    br_q   <= bus.br_in;
                    bi_q   <= bus.bi_in;
                    re_acc <= '0;
                    im_acc <= '0;
                    idx    <= '0;
                end
                WAIT: begin
                    if (bus.mul_ready) begin
                        case (idx)
                            2'd0:    re_acc <= re_acc + prod_ext;
                            2'd1:    re_acc <= re_acc - prod_ext;
                            default: im_acc <= im_acc + prod_ext;
                        endcase
                        if (idx != 2'd3) idx <= idx + 2'd1;
                    end else if (timeout) begin
                        re_acc <= '0;
                        im_acc <= '0;
                    end
                end
                // First DONE cycle publishes the result; it then holds until taken.
                DONE: begin
                    if (!out_valid_q) begin
                        out_valid_q <= 1'b1;
                        re_q        <= re_acc;
                        im_q        <= im_acc;
                    end else if (bus.out_ready) begin
                        out_valid_q <= 1'b0;
                    end
                end
                default: ;
            endcase
        end
    end
endmodule
